// File: rtl/byte_stream_router.sv
// byte_stream_router: merges several byte sources into one tagged,
// FIFO-buffered stream using fixed-select or round-robin arbitration.
module byte_stream_router #(
  parameter  int INPUTS = 2,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int SW     = $clog2(INPUTS),
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_low,
  input  logic                    mode,
  input  logic [SW-1:0]           select,
  input  logic [INPUTS-1:0]       in_valid,
  output logic [INPUTS-1:0]       in_ready,
  input  logic [INPUTS*WIDTH-1:0] in_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_byte,
  output logic [SW-1:0]           out_channel,
  output logic [LW-1:0]           level
);

  localparam int  AW   = $clog2(DEPTH);
  localparam int  EW   = SW + WIDTH;
  localparam bit  POW2 = ((1 << SW) == INPUTS);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [SW-1:0]    rr_q, rr_d;

  logic             full;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SW-1:0]    gnt;
  logic [SW-1:0]    cand;
  logic [SW-1:0]    push_ch;
  logic [WIDTH-1:0] push_byte;
  logic             push;
  logic             pop;

  assign full   = (lvl_q == LW'(DEPTH));
  assign sel_ok = POW2 ? 1'b1 : (int'(select) < INPUTS);

  // Round-robin search: walk from farthest to nearest so the nearest
  // valid channel after rr_q is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = rr_q;
    cand    = rr_q;
    for (int k = INPUTS; k >= 1; k--) begin
      cand = SW'((int'(rr_q) + k) % INPUTS);
      if (in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  // Accept decision: one channel at most, nothing while full or in reset.
  always_comb begin
    in_ready = '0;
    push_ch  = select;
    if (reset_low && !full) begin
      unique case (1'b1)
        !mode: begin
          if (sel_ok) in_ready[select] = 1'b1;
        end
        mode: begin
          push_ch = gnt;
          if (gnt_vld) in_ready[gnt] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data mux for the accepted channel.
  always_comb begin
    push_byte = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (push_ch == SW'(i)) push_byte = in_byte[i*WIDTH +: WIDTH];
    end
  end

  assign push = |(in_ready & in_valid);
  assign pop  = out_valid & out_ready;

  // Next-state for pointers, level and arbiter. rr only tracks
  // round-robin transfers; fixed-select traffic leaves it alone.
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q;
    if (push && !pop) lvl_d = lvl_q + 1'b1;
    if (pop && !push) lvl_d = lvl_q - 1'b1;
    rr_d  = (push && mode) ? push_ch : rr_q;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {push_ch, push_byte};
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      rr_q  <= SW'(INPUTS - 1);
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      rr_q  <= rr_d;
    end
  end

  assign out_valid = (lvl_q != '0);
  assign level     = lvl_q;

  // Head word is forced to zero when empty so reset shows clean outputs.
  always_comb begin
    {out_channel, out_byte} = out_valid ? mem_q[rd_q] : '0;
  end

endmodule
